// File: rtl/miner_host_master.sv
// miner_host_master
//   Avalon-MM master that loads one mining job into the miner CSR slave
//   (clear control, 8 target words, 19 header words, start pulse), polls the
//   status word until the miner reports complete, optionally reads the found
//   nonce, and offers the outcome on a ready/valid result port.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   job_valid/ready     job handshake; job_msg (608b header) and
//                       job_target (256b) are latched on acceptance
//   result_valid/ready  result handshake; result_found, result_nonce,
//                       result_err held stable while result_valid is high
//   busy                high in every state except IDLE
//   m_*                 Avalon-MM master (no waitrequest, read data valid
//                       exactly one cycle after m_read)
//
// Build option
//   MINER_HOST_TIMEOUT_EN  when defined, give up after TIMEOUT_POLLS status
//                          reads that see complete = 0, clear the control
//                          word and report result_err = 1.
module miner_host_master #(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter int unsigned STATUS_ADDR   = 30,
    parameter int unsigned NONCE_ADDR    = 31,
    parameter int unsigned TIMEOUT_POLLS = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [607:0] job_msg,
    input  logic [255:0] job_target,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         result_found,
    output logic [31:0]  result_nonce,
    output logic         result_err,
    output logic         busy,
    output logic [4:0]   m_address,
    output logic [31:0]  m_writedata,
    output logic         m_write,
    output logic         m_read,
    output logic         m_chipselect,
    input  logic [31:0]  m_readdata
);

    typedef enum logic [3:0] {
        IDLE, CLR, WR_TGT, WR_MSG, START, WAIT, POLL_RD, POLL_CHK,
        NONCE_RD, NONCE_CHK, TO_CLR, DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(POLL_INTERVAL - 1);

    state_t            state, nextState;
    logic [7:0]        cnt;
    logic [7:0][31:0]  tgtWords;
    logic [18:0][31:0] msgWords;
    logic              resFound;
    logic [31:0]       resNonce;

`ifdef MINER_HOST_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_POLLS - 1);
    logic [15:0] pollCnt;
    logic        resErr;
`endif

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:      if (job_valid) nextState = CLR;
            CLR:       nextState = WR_TGT;
            WR_TGT:    if (cnt == 8'd7) nextState = WR_MSG;
            WR_MSG:    if (cnt == 8'd18) nextState = START;
            START:     nextState = WAIT;
            WAIT:      if (cnt == WAIT_LAST) nextState = POLL_RD;
            POLL_RD:   nextState = POLL_CHK;
            POLL_CHK: begin
                if (m_readdata[0]) begin
                    nextState = m_readdata[1] ? NONCE_RD : DONE;
                end else begin
`ifdef MINER_HOST_TIMEOUT_EN
                    nextState = (pollCnt == TIMEOUT_LAST) ? TO_CLR : WAIT;
`else
                    nextState = WAIT;
`endif
                end
            end
            NONCE_RD:  nextState = NONCE_CHK;
            NONCE_CHK: nextState = DONE;
            TO_CLR:    nextState = DONE;
            DONE:      if (result_ready) nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_comb begin
        m_address   = '0;
        m_writedata = '0;
        m_write     = 1'b0;
        m_read      = 1'b0;
        unique case (state)
            CLR, TO_CLR: begin
                m_write   = 1'b1;
                m_address = 5'd1;
            end
            WR_TGT: begin
                m_write     = 1'b1;
                m_address   = 5'd2 + cnt[4:0];
                m_writedata = tgtWords[cnt[2:0]];
            end
            WR_MSG: begin
                m_write     = 1'b1;
                m_address   = 5'd11 + cnt[4:0];
                m_writedata = msgWords[cnt[4:0]];
            end
            START: begin
                m_write     = 1'b1;
                m_address   = 5'd1;
                m_writedata = 32'h3;
            end
            POLL_RD: begin
                m_read    = 1'b1;
                m_address = 5'(STATUS_ADDR);
            end
            NONCE_RD: begin
                m_read    = 1'b1;
                m_address = 5'(NONCE_ADDR);
            end
            default: ;
        endcase
    end

    assign m_chipselect = m_write | m_read;
    assign job_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);
    assign result_found = resFound;
    assign result_nonce = resNonce;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            resFound <= 1'b0;
            resNonce <= '0;
`ifdef MINER_HOST_TIMEOUT_EN
            pollCnt  <= '0;
            resErr   <= 1'b0;
`endif
        end else begin
            state <= nextState;
            // One shared counter: restarts on every state change, so it
            // indexes words in the write states and times the poll gap in WAIT.
            cnt   <= (nextState == state) ? cnt + 8'd1 : '0;

            if (state == IDLE && job_valid) begin
                tgtWords <= job_target;
                msgWords <= job_msg;
                resFound <= 1'b0;
                resNonce <= '0;
`ifdef MINER_HOST_TIMEOUT_EN
                resErr   <= 1'b0;
`endif
            end
            if (state == POLL_CHK && m_readdata[0] && !m_readdata[1]) begin
                resFound <= 1'b0;
                resNonce <= '0;
            end
            if (state == NONCE_CHK) begin
                resFound <= 1'b1;
                resNonce <= m_readdata;
            end
`ifdef MINER_HOST_TIMEOUT_EN
            if (state == START) pollCnt <= '0;
            if (state == POLL_CHK && !m_readdata[0]) pollCnt <= pollCnt + 16'd1;
            if (state == POLL_CHK && nextState == TO_CLR) begin
                resErr   <= 1'b1;
                resFound <= 1'b0;
                resNonce <= '0;
            end
`endif
        end
    end

`ifdef MINER_HOST_TIMEOUT_EN
    assign result_err = resErr;
`else
    // Timeout logic absent: TIMEOUT_POLLS has no effect and result_err stays low.
    assign result_err = (TIMEOUT_POLLS == 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_miner_host_master.sv
`timescale 1ns/1ps
module tb_miner_host_master;

    localparam int PI = 5;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         job_valid = 1'b0;
    logic         job_ready;
    logic [607:0] job_msg = '0;
    logic [255:0] job_target = '0;
    logic         result_valid;
    logic         result_ready = 1'b0;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic         result_err;
    logic         busy;
    logic [4:0]   m_address;
    logic [31:0]  m_writedata;
    logic         m_write;
    logic         m_read;
    logic         m_chipselect;
    logic [31:0]  m_readdata = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    miner_host_master #(
        .POLL_INTERVAL(PI),
        .STATUS_ADDR(30),
        .NONCE_ADDR(31),
        .TIMEOUT_POLLS(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg(job_msg), .job_target(job_target),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_found(result_found), .result_nonce(result_nonce),
        .result_err(result_err), .busy(busy),
        .m_address(m_address), .m_writedata(m_writedata),
        .m_write(m_write), .m_read(m_read),
        .m_chipselect(m_chipselect), .m_readdata(m_readdata)
    );

    int nVec = 0;
    int nErr = 0;
    int cyc = 0;
    int protoErr = 0;
    int accT = 0;

    typedef struct {
        int          t;
        bit          wr;
        logic [4:0]  a;
        logic [31:0] d;
    } ev_t;
    ev_t evq[$];

    logic [31:0] stScript[$];
    logic [31:0] stDefault = 32'h0;
    logic [31:0] nonceVal = 32'h0;

    // Bus monitor: one sample per cycle, mid-cycle.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_write || m_read) begin
            ev_t e;
            e.t = cyc; e.wr = m_write; e.a = m_address; e.d = m_writedata;
            evq.push_back(e);
        end
        if (m_write && m_read) protoErr = protoErr + 1;
        if (m_chipselect !== (m_write | m_read)) protoErr = protoErr + 1;
        if (!m_write && !m_read && (m_address !== 5'd0 || m_writedata !== 32'd0))
            protoErr = protoErr + 1;
    end

    // Miner CSR slave model: read data appears the cycle after m_read.
    always @(posedge clk) begin
        if (m_read) begin
            if (m_address == 5'd30) begin
                if (stScript.size() > 0) m_readdata <= stScript.pop_front();
                else                     m_readdata <= stDefault;
            end else if (m_address == 5'd31) begin
                m_readdata <= nonceVal;
            end else begin
                m_readdata <= 32'hFFFF_FFFF;
            end
        end else begin
            m_readdata <= 32'hFFFF_FFFF;
        end
    end

    task automatic startJob(input logic [255:0] tgt, input logic [607:0] msg, output int acc);
        @(negedge clk); #1;
        job_target = tgt;
        job_msg    = msg;
        job_valid  = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        job_valid = 1'b0;
    endtask

    task automatic waitValid(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk); #1;
            if (result_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        nVec++; if (job_ready !== 1'b1) begin nErr++; $display("FAIL reset job_ready got %b want 1", job_ready); end
        nVec++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset busy got %b want 0", busy); end
        nVec++; if (result_valid !== 1'b0) begin nErr++; $display("FAIL reset result_valid got %b want 0", result_valid); end
        nVec++; if (result_found !== 1'b0 || result_err !== 1'b0) begin nErr++; $display("FAIL reset found/err got %b/%b want 0/0", result_found, result_err); end
        nVec++; if (result_nonce !== 32'h0) begin nErr++; $display("FAIL reset result_nonce got %h want 0", result_nonce); end
        nVec++; if ({m_write, m_read, m_chipselect} !== 3'b000) begin nErr++; $display("FAIL reset strobes got %b want 000", {m_write, m_read, m_chipselect}); end
        nVec++; if (m_address !== 5'd0 || m_writedata !== 32'd0) begin nErr++; $display("FAIL reset addr/data got %h/%h want 0/0", m_address, m_writedata); end
        rst = 1'b0;
    endtask

    task automatic test_write_seq;
        logic [607:0] msg;
        int ea;
        logic [31:0] ed;
        int n;
        for (int k = 0; k < 19; k++) msg[32*k +: 32] = 32'(k);
        stScript = {32'h0, 32'h0, 32'h0, 32'h3};
        nonceVal = 32'h0000_1234;
        stDefault = 32'h0;
        evq.delete();
        startJob({256{1'b1}}, msg, accT);
        repeat (30) @(negedge clk);
        #1;
        nVec++; if (evq.size() != 29) begin nErr++; $display("FAIL wr_count got %0d want 29", evq.size()); end
        n = (evq.size() < 29) ? evq.size() : 29;
        for (int i = 0; i < n; i++) begin
            if (i == 0)      begin ea = 1;            ed = 32'h0; end
            else if (i < 9)  begin ea = 2 + (i - 1);  ed = 32'hFFFF_FFFF; end
            else if (i < 28) begin ea = 11 + (i - 9); ed = 32'(i - 9); end
            else             begin ea = 1;            ed = 32'h3; end
            nVec++;
            if (evq[i].wr !== 1'b1 || evq[i].a !== 5'(ea) || evq[i].d !== ed || evq[i].t != accT + 1 + i) begin
                nErr++;
                $display("FAIL wr_seq[%0d] got wr=%b a=%0d d=%h t=%0d want wr=1 a=%0d d=%h t=%0d",
                         i, evq[i].wr, evq[i].a, evq[i].d, evq[i].t, ea, ed, accT + 1 + i);
            end
        end
    endtask

    task automatic test_poll_found;
        bit ok;
        ev_t rd[$];
        waitValid(300, ok);
        nVec++; if (!ok) begin nErr++; $display("FAIL found_valid got timeout want result_valid"); end
        foreach (evq[i]) if (!evq[i].wr) rd.push_back(evq[i]);
        nVec++; if (rd.size() != 5) begin nErr++; $display("FAIL found_reads got %0d want 5", rd.size()); end
        if (rd.size() == 5) begin
            nVec++; if (rd[0].t != accT + 30 + PI) begin nErr++; $display("FAIL first_poll_t got %0d want %0d", rd[0].t, accT + 30 + PI); end
            for (int j = 1; j < 4; j++) begin
                nVec++;
                if (rd[j].a !== 5'd30 || rd[j].t - rd[j-1].t != PI + 2) begin
                    nErr++;
                    $display("FAIL poll[%0d] got a=%0d gap=%0d want a=30 gap=%0d", j, rd[j].a, rd[j].t - rd[j-1].t, PI + 2);
                end
            end
            nVec++; if (rd[4].a !== 5'd31 || rd[4].t != rd[3].t + 2) begin nErr++; $display("FAIL nonce_rd got a=%0d t=%0d want a=31 t=%0d", rd[4].a, rd[4].t, rd[3].t + 2); end
            nVec++; if (cyc != rd[4].t + 2) begin nErr++; $display("FAIL done_t got %0d want %0d", cyc, rd[4].t + 2); end
        end
        nVec++; if (result_found !== 1'b1) begin nErr++; $display("FAIL found_flag got %b want 1", result_found); end
        nVec++; if (result_nonce !== 32'h0000_1234) begin nErr++; $display("FAIL found_nonce got %h want 00001234", result_nonce); end
        nVec++; if (result_err !== 1'b0) begin nErr++; $display("FAIL found_err got %b want 0", result_err); end
    endtask

    task automatic test_hold_done;
        int nEv;
        nEv = evq.size();
        result_ready = 1'b0;
        job_target = 256'h1;
        job_valid  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            nVec++;
            if (result_valid !== 1'b1 || result_found !== 1'b1 || result_nonce !== 32'h0000_1234 ||
                result_err !== 1'b0 || job_ready !== 1'b0 || busy !== 1'b1) begin
                nErr++;
                $display("FAIL hold[%0d] got v=%b f=%b n=%h e=%b jr=%b b=%b want v=1 f=1 n=00001234 e=0 jr=0 b=1",
                         i, result_valid, result_found, result_nonce, result_err, job_ready, busy);
            end
        end
        nVec++; if (evq.size() != nEv) begin nErr++; $display("FAIL hold_bus got %0d events want %0d", evq.size(), nEv); end
        job_valid = 1'b0;
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        @(negedge clk); #1;
        nVec++; if (job_ready !== 1'b1 || result_valid !== 1'b0 || busy !== 1'b0) begin nErr++; $display("FAIL post_hs got jr=%b v=%b b=%b want jr=1 v=0 b=0", job_ready, result_valid, busy); end
    endtask

    task automatic test_not_found;
        bit ok;
        int nRd;
        int nNonce;
        stScript = {32'h1};
        evq.delete();
        result_ready = 1'b1;
        startJob({8{32'h0F0F_1234}}, {19{32'hCAFE_0001}}, accT);
        waitValid(300, ok);
        nVec++; if (!ok) begin nErr++; $display("FAIL nf_valid got timeout want result_valid"); end
        nRd = 0; nNonce = 0;
        foreach (evq[i]) if (!evq[i].wr) begin nRd++; if (evq[i].a == 5'd31) nNonce++; end
        nVec++; if (nRd != 1 || nNonce != 0) begin nErr++; $display("FAIL nf_reads got %0d reads %0d nonce want 1 reads 0 nonce", nRd, nNonce); end
        nVec++; if (result_found !== 1'b0 || result_nonce !== 32'h0) begin nErr++; $display("FAIL nf_result got f=%b n=%h want f=0 n=0", result_found, result_nonce); end
        @(negedge clk); #1;
        nVec++; if (result_valid !== 1'b0 || job_ready !== 1'b1) begin nErr++; $display("FAIL nf_hs got v=%b jr=%b want v=0 jr=1", result_valid, job_ready); end
        result_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int nAtRst;
        int acc;
        stScript.delete();
        stDefault = 32'h0;
        evq.delete();
        startJob({256{1'b0}}, {19{32'h5555_AAAA}}, acc);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (evq.size() >= 15) break;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nAtRst = evq.size();
        nVec++; if (nAtRst != 15) begin nErr++; $display("FAIL rst_mid_count got %0d want 15", nAtRst); end
        @(negedge clk); #1;
        nVec++; if (job_ready !== 1'b1 || busy !== 1'b0 || m_write !== 1'b0) begin nErr++; $display("FAIL rst_mid_state got jr=%b b=%b w=%b want jr=1 b=0 w=0", job_ready, busy, m_write); end
        repeat (40) @(negedge clk);
        #1;
        nVec++; if (evq.size() != nAtRst) begin nErr++; $display("FAIL rst_mid_quiet got %0d events want %0d", evq.size(), nAtRst); end
    endtask

`ifdef MINER_HOST_TIMEOUT_EN
    task automatic test_timeout;
        bit ok;
        ev_t rd[$];
        ev_t last;
        stScript.delete();
        stDefault = 32'h0;
        evq.delete();
        startJob({256{1'b1}}, {19{32'h1}}, accT);
        waitValid(400, ok);
        nVec++; if (!ok) begin nErr++; $display("FAIL to_valid got timeout want result_valid"); end
        foreach (evq[i]) if (!evq[i].wr) rd.push_back(evq[i]);
        nVec++; if (rd.size() != TO) begin nErr++; $display("FAIL to_reads got %0d want %0d", rd.size(), TO); end
        if (evq.size() > 0 && rd.size() > 0) begin
            last = evq[evq.size() - 1];
            nVec++;
            if (last.wr !== 1'b1 || last.a !== 5'd1 || last.d !== 32'h0 || last.t != rd[rd.size() - 1].t + 2) begin
                nErr++;
                $display("FAIL to_clr got wr=%b a=%0d d=%h t=%0d want wr=1 a=1 d=0 t=%0d", last.wr, last.a, last.d, last.t, rd[rd.size() - 1].t + 2);
            end
        end
        nVec++; if (result_err !== 1'b1 || result_found !== 1'b0 || result_nonce !== 32'h0) begin nErr++; $display("FAIL to_result got e=%b f=%b n=%h want e=1 f=0 n=0", result_err, result_found, result_nonce); end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask
`endif

    task automatic test_bus_rules;
        nVec++; if (protoErr != 0) begin nErr++; $display("FAIL bus_rules got %0d violations want 0", protoErr); end
    endtask

    initial begin
        test_reset();
        test_write_seq();
        test_poll_found();
        test_hold_done();
        test_not_found();
        test_reset_mid();
`ifdef MINER_HOST_TIMEOUT_EN
        test_timeout();
`endif
        test_bus_rules();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
